// File: rtl/dsp_mul_seq_pkg.sv
// Shared encodings for the sequential RV32M multiplier: op codes, FSM states
// and the signed-correction helper applied to the upper product word.
package dsp_mul_seq_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4,
        S_CORR = 3'd5,
        S_DONE = 3'd6
    } mul_state_e;

    // Converts the unsigned upper word into the signed/mixed upper word by
    // subtracting b when a is negative and a when b is negative (mod 2^32).
    function automatic logic [31:0] corr_hi(
        input logic [31:0] acc_hi,
        input mul_op_e     op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] ca;
        logic [31:0] cb;
        ca = ((op == MUL_OP_MULH || op == MUL_OP_MULHSU) && a[31]) ? b : 32'd0;
        cb = (op == MUL_OP_MULH && b[31]) ? a : 32'd0;
        return acc_hi - ca - cb;
    endfunction

endpackage

// File: rtl/dsp_mul_seq_mul16x16u.sv
// 16x16 -> 32 unsigned combinational product, either on an SB_MAC16 hard
// multiplier or as a plain fabric multiply.
module mul16x16u #(
    parameter int USE_DSP = 1
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] p
);

    generate
        if (USE_DSP != 0) begin : g_dsp
            SB_MAC16 #(
                .TOPOUTPUT_SELECT (2'b11),
                .BOTOUTPUT_SELECT (2'b11),
                .A_SIGNED         (1'b0),
                .B_SIGNED         (1'b0)
            ) u_mac (
                .A (x),
                .B (y),
                .O (p)
            );
        end else begin : g_fabric
            assign p = {16'd0, x} * {16'd0, y};
        end
    endgenerate

endmodule

// File: rtl/sb_mac16.sv
// Behavioural stand-in for the iCE40 SB_MAC16 in its unregistered 16x16 unsigned
// multiply configuration; leave it out of builds that link the vendor cell library.
module SB_MAC16 #(
    parameter logic [1:0] TOPOUTPUT_SELECT = 2'b00,
    parameter logic [1:0] BOTOUTPUT_SELECT = 2'b00,
    parameter logic       A_SIGNED         = 1'b0,
    parameter logic       B_SIGNED         = 1'b0
) (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] O
);

    logic [31:0] prod;
    logic        mul_mode;

    assign prod     = {16'd0, A} * {16'd0, B};
    assign mul_mode = !A_SIGNED && !B_SIGNED;

    // Output select 2'b11 routes the raw multiplier output past the accumulators.
    assign O[31:16] = (mul_mode && TOPOUTPUT_SELECT == 2'b11) ? prod[31:16] : 16'd0;
    assign O[15:0]  = (mul_mode && BOTOUTPUT_SELECT == 2'b11) ? prod[15:0]  : 16'd0;

endmodule

// File: rtl/dsp_mul_seq.sv
// Sequential 32x32 RV32M multiplier: four 16x16 partial products accumulated
// over PP0..PP3, signed correction of the upper word in CORR, registered result.
module dsp_mul_seq #(
    parameter int USE_DSP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    import dsp_mul_seq_pkg::*;

    mul_state_e  state_q, state_d;
    mul_op_e     op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] mul_x;
    logic [15:0] mul_y;
    logic [31:0] prod;
    logic [63:0] prod_ext;

    mul16x16u #(
        .USE_DSP (USE_DSP)
    ) u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (prod)
    );

    // Half-select and alignment of the one partial product formed this cycle.
    always_comb begin
        mul_x    = a_q[15:0];
        mul_y    = b_q[15:0];
        prod_ext = 64'd0;
        case (state_q)
            S_PP0: prod_ext = {32'd0, prod};
            S_PP1: begin
                mul_x    = a_q[31:16];
                prod_ext = {16'd0, prod, 16'd0};
            end
            S_PP2: begin
                mul_y    = b_q[31:16];
                prod_ext = {16'd0, prod, 16'd0};
            end
            S_PP3: begin
                mul_x    = a_q[31:16];
                mul_y    = b_q[31:16];
                prod_ext = {prod, 32'd0};
            end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // signal unassigned; that keeps this block free of inferred latches.
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_PP0;
                    op_d    = mul_op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 64'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PP0: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_PP1;
            end
            S_PP1: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_PP2;
            end
            S_PP2: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_PP3;
            end
            S_PP3: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_CORR;
            end
            S_CORR: begin
                result_d = (op_q == MUL_OP_MUL) ? acc_q[31:0]
                                                : corr_hi(acc_q[63:32], op_q, a_q, b_q);
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_PP0) || (state_d == S_PP1) || (state_d == S_PP2) ||
                 (state_d == S_PP3) || (state_d == S_CORR);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= MUL_OP_MUL;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_dsp_mul_seq.sv
// Scoreboard bench for dsp_mul_seq: stimulus pushes expected result and done
// cycle; a negedge monitor pops and compares whenever done is presented.
module tb_dsp_mul_seq;
    import dsp_mul_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    dsp_mul_seq #(
        .USE_DSP (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        int unsigned at;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_latency"}, cyc, e.at);
            end
        end
    end

    task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a  = x;
        b  = y;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] r);
        @(negedge clk);
        drive(o, x, y);
        start = 1'b1;
        sb_q.push_back('{nm, r, cyc + 6});
        @(negedge clk);
        start = 1'b0;
        wait_done(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned c;
        int          busy_n;

        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        run_op("t1_mulhu_ones",   MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("t2_mul_ones",     MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("t2_mulh_ones",    MUL_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("t3_mulh_min",     MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("t3_mulhsu_min",   MUL_OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000);
        run_op("t3_mulhu_min",    MUL_OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        // -1 * 2 = -2, upper word all ones
        run_op("x_mulh_neg",      MUL_OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        // 2 * (2^32-1) = 0x1_FFFF_FFFE
        run_op("x_mulhsu_pos",    MUL_OP_MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001);
        // (2^31-1)^2 = 0x3FFF_FFFF_0000_0001
        run_op("x_mulh_max",      MUL_OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF);
        run_op("x_mul_zero",      MUL_OP_MUL,    32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000);

        // t4: 0x12345 * 0x67890 = 0x7_5CCA_2ED0; a second start in PP2 is ignored.
        @(negedge clk);
        drive(MUL_OP_MUL, 32'h0001_2345, 32'h0006_7890);
        start = 1'b1;
        c = cyc;
        sb_q.push_back('{"t4_mul_ignore_start", 32'h5CCA_2ED0, c + 6});
        @(negedge clk);
        start = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) busy_n++;
            start = (cyc == c + 3);
            if (start) drive(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        start = 1'b0;
        check("t4_done_seen",    {31'd0, done}, 32'd1);
        check("t4_busy_cycles",  busy_n, 32'd5);
        check("t4_busy_at_done", {31'd0, busy}, 32'd0);

        // t5: start held through DONE; second op latched at the DONE edge.
        @(negedge clk);
        drive(MUL_OP_MULHU, 32'h0001_0000, 32'h0001_0000);
        start = 1'b1;
        c = cyc;
        sb_q.push_back('{"t5_first",  32'h0000_0001, c + 6});
        sb_q.push_back('{"t5_second", 32'hFFFF_FFFF, c + 12});
        @(negedge clk);
        drive(MUL_OP_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003);
        for (int i = 0; i < 20 && cyc != c + 7; i++) @(negedge clk);
        start = 1'b0;
        check("t5_second_accept_busy", {31'd0, busy}, 32'd1);
        wait_done("t5_second");

        // t6: asynchronous reset in PP1 aborts the operation.
        @(negedge clk);
        drive(MUL_OP_MUL, 32'h0000_1234, 32'h0000_5678);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t6_busy_before_rst", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy",   {31'd0, busy}, 32'd0);
        check("t6_rst_done",   {31'd0, done}, 32'd0);
        check("t6_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_no_stale_done", {31'd0, done}, 32'd0);
        run_op("t6_mul_after_rst", MUL_OP_MUL, 32'd7, 32'd6, 32'd42);

        repeat (10) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
